// File: rtl/countdown_timer_if.sv
// Purpose : groups the countdown timer's control inputs and status outputs into one bundle.
// Latency : n/a (wires only).
// Backpressure: none; the timer samples every control input on every clock edge.
//
// Signals:
//   LOADVAL       [15:0] countdown start value in seconds (driver -> timer)
//   nLOAD                active-low load strobe            (driver -> timer)
//   nSTART               active-low start strobe           (driver -> timer)
//   nPAUSE               active-low level hold             (driver -> timer)
//   TIMEREMAINING [15:0] seconds left                      (timer -> driver)
//   BUSY                 high while running or paused      (timer -> driver)
//   EXPIRED              expiry indication                 (timer -> driver)
// Modports: master = controlling side, slave = the timer itself.
interface countdown_timer_if;
  logic [15:0] LOADVAL;
  logic        nLOAD;
  logic        nSTART;
  logic        nPAUSE;
  logic [15:0] TIMEREMAINING;
  logic        BUSY;
  logic        EXPIRED;

  modport master (
    output LOADVAL,
    output nLOAD,
    output nSTART,
    output nPAUSE,
    input  TIMEREMAINING,
    input  BUSY,
    input  EXPIRED
  );

  modport slave (
    input  LOADVAL,
    input  nLOAD,
    input  nSTART,
    input  nPAUSE,
    output TIMEREMAINING,
    output BUSY,
    output EXPIRED
  );
endinterface

// File: rtl/countdown_timer.sv
// Purpose : seconds countdown timer with load/start/pause control and expiry flag.
// Latency : all outputs registered; a control strobe takes effect on the edge that samples it.
// Backpressure: none; nLOAD/nSTART/nPAUSE are sampled every MCLK edge.
//
// Ports:
//   MCLK    - the only clock, rising edge
//   nRESET  - synchronous active-low reset, overrides everything
//   bus     - countdown_timer_if.slave (LOADVAL, nLOAD, nSTART, nPAUSE in;
//             TIMEREMAINING, BUSY, EXPIRED out)
// Parameter PRESCALE: MCLK cycles per one-second tick (2 .. 2^24-1).
// Build option COUNTDOWN_AUTORELOAD_EN: when defined, expiry reloads the count
// from the shadow register and stays in RUN, pulsing EXPIRED for one cycle;
// when undefined, expiry goes to DONE and EXPIRED is held as a level.
module countdown_timer #(
  parameter int unsigned PRESCALE = 8192
) (
  input  logic                MCLK,
  input  logic                nRESET,
  countdown_timer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Terminal prescaler value; the tick fires on the edge that sees it.
  localparam logic [23:0] PRESC_LAST = 24'(PRESCALE - 1);

  // Registers carry power-up values matching the reset values.
  state_t      state_q   = IDLE;
  logic [23:0] presc_q   = '0;
  logic [15:0] shadow_q  = '0;
  logic [15:0] tr_q      = '0;
  logic        busy_q    = 1'b0;
  logic        expired_q = 1'b0;

  state_t      state_d;
  logic [23:0] presc_d;
  logic [15:0] shadow_d;
  logic [15:0] tr_d;
  logic        busy_d;
  logic        expired_d;
  logic        count_en;

  // ------------------------------------------------------------------
  // Next-state and datapath
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    shadow_d  = shadow_q;
    tr_d      = tr_q;
    expired_d = expired_q;
    count_en  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (!bus.nLOAD) begin
          // Load wins over a simultaneous start; start needs a later edge.
          tr_d      = bus.LOADVAL;
          shadow_d  = bus.LOADVAL;
          expired_d = 1'b0;
          state_d   = IDLE;
        end else if ((state_q == IDLE) && !bus.nSTART) begin
          presc_d = '0;
          if (tr_q != 16'd0) begin
            state_d = RUN;
          end else begin
            // Nothing to count: expire immediately, also in auto-reload builds.
            state_d   = DONE;
            expired_d = 1'b1;
          end
        end
      end

      RUN: begin
        // Pause has priority, even on the edge that would otherwise tick.
        if (!bus.nPAUSE) begin
          state_d = PAUSED;
        end else begin
          count_en = 1'b1;
        end
      end

      PAUSED: begin
        // The resume edge itself counts, so a pause of N low cycles
        // delays expiry by exactly N cycles.
        if (bus.nPAUSE) begin
          state_d  = RUN;
          count_en = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // EXPIRED can only be high while counting as a one-cycle auto-reload
    // pulse; drop it on the next edge. In the level build it is already low.
    if ((state_q == RUN) || (state_q == PAUSED)) begin
      expired_d = 1'b0;
    end

    if (count_en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (tr_q > 16'd1) begin
          tr_d = tr_q - 16'd1;
        end else if (tr_q == 16'd1) begin
          expired_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          tr_d      = shadow_q;
`else
          tr_d      = 16'd0;
          state_d   = DONE;
`endif
        end
        // tr_q == 0 cannot occur while counting; holding at 0 keeps the
        // count from wrapping.
      end else begin
        presc_d = presc_q + 24'd1;
      end
    end

    busy_d = (state_d == RUN) || (state_d == PAUSED);
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge MCLK) begin
    if (!nRESET) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      shadow_q  <= '0;
      tr_q      <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      shadow_q  <= shadow_d;
      tr_q      <= tr_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

  assign bus.TIMEREMAINING = tr_q;
  assign bus.BUSY          = busy_q;
  assign bus.EXPIRED       = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int ST_IDLE   = 0;
  localparam int ST_RUN    = 1;
  localparam int ST_PAUSED = 2;
  localparam int ST_DONE   = 3;

  logic MCLK = 1'b0;
  logic nRESET;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  countdown_timer_if bus();

  countdown_timer #(.PRESCALE(4)) dut (
    .MCLK   (MCLK),
    .nRESET (nRESET),
    .bus    (bus.slave)
  );

  always #5 MCLK = ~MCLK;

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int tr, input int busy, input int expd);
    chk({tag, " tr"},   32'(bus.TIMEREMAINING), 32'(tr));
    chk({tag, " busy"}, 32'(bus.BUSY),          32'(busy));
    chk({tag, " exp"},  32'(bus.EXPIRED),       32'(expd));
  endtask

  initial begin
    nRESET      = 1'b0;
    bus.LOADVAL = 16'd0;
    bus.nLOAD   = 1'b1;
    bus.nSTART  = 1'b1;
    bus.nPAUSE  = 1'b1;

    // Reset state
    tick();
    chk_out("reset", 0, 0, 0);
    chk("reset state", 32'(dut.state_q), ST_IDLE);
    nRESET = 1'b1;

`ifndef COUNTDOWN_AUTORELOAD_EN
    // Load 3, start, count down 3,2,1,0 at 4/8/12 cycles after RUN entry
    bus.LOADVAL = 16'd3;
    bus.nLOAD   = 1'b0;
    tick();
    chk_out("A load", 3, 0, 0);
    bus.nLOAD  = 1'b1;
    bus.nSTART = 1'b0;
    tick();
    chk_out("A entry", 3, 1, 0);
    chk("A entry state", 32'(dut.state_q), ST_RUN);
    bus.nSTART = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_out($sformatf("A k=%0d", k), 3 - k / 4, (k < 12) ? 1 : 0, (k == 12) ? 1 : 0);
    end
    chk("A done state", 32'(dut.state_q), ST_DONE);
    tick();
    chk_out("A hold", 0, 0, 1);
    // Start ignored in DONE
    bus.nSTART = 1'b0;
    tick();
    chk_out("A start in DONE", 0, 0, 1);
    chk("A start in DONE state", 32'(dut.state_q), ST_DONE);
    bus.nSTART = 1'b1;

    // Load 0, start -> immediate DONE, BUSY never high
    bus.LOADVAL = 16'd0;
    bus.nLOAD   = 1'b0;
    tick();
    chk_out("B load0", 0, 0, 0);
    bus.nLOAD  = 1'b1;
    bus.nSTART = 1'b0;
    tick();
    chk_out("B start0", 0, 0, 1);
    chk("B state", 32'(dut.state_q), ST_DONE);
    bus.nSTART = 1'b1;
    tick();
    chk_out("B hold", 0, 0, 1);

    // Load 2, pause 10 cycles starting on the terminal-tick edge:
    // expiry moves from 8 to 18 cycles after RUN entry
    bus.LOADVAL = 16'd2;
    bus.nLOAD   = 1'b0;
    tick();
    bus.nLOAD  = 1'b1;
    bus.nSTART = 1'b0;
    tick();
    chk_out("C entry", 2, 1, 0);
    bus.nSTART = 1'b1;
    begin
      int active;
      active = 0;
      for (int k = 1; k <= 18; k++) begin
        bus.nPAUSE = (k >= 4 && k <= 13) ? 1'b0 : 1'b1;
        tick();
        if (bus.nPAUSE) active++;
        chk_out($sformatf("C k=%0d", k), 2 - active / 4,
                (active < 8) ? 1 : 0, (active == 8) ? 1 : 0);
        if (k == 4 || k == 13)
          chk($sformatf("C paused state k=%0d", k), 32'(dut.state_q), ST_PAUSED);
      end
    end
    chk("C done state", 32'(dut.state_q), ST_DONE);
    bus.nPAUSE = 1'b1;

    // Reset mid-RUN with 5 seconds, then start gives immediate DONE
    bus.LOADVAL = 16'd5;
    bus.nLOAD   = 1'b0;
    tick();
    bus.nLOAD  = 1'b1;
    bus.nSTART = 1'b0;
    tick();
    bus.nSTART = 1'b1;
    tick();
    tick();
    tick();
    chk_out("D before reset", 5, 1, 0);
    nRESET = 1'b0;
    tick();
    chk_out("D reset", 0, 0, 0);
    chk("D reset state", 32'(dut.state_q), ST_IDLE);
    chk("D reset presc", 32'(dut.presc_q), 0);
    nRESET     = 1'b1;
    bus.nSTART = 1'b0;
    tick();
    chk_out("D start after reset", 0, 0, 1);
    chk("D start state", 32'(dut.state_q), ST_DONE);
    bus.nSTART = 1'b1;

    // Load and start on the same edge: load only; later nLOAD ignored in RUN
    bus.LOADVAL = 16'd1;
    bus.nLOAD   = 1'b0;
    tick();
    bus.LOADVAL = 16'd7;
    bus.nSTART  = 1'b0;
    tick();
    chk_out("E load+start", 7, 0, 0);
    chk("E state", 32'(dut.state_q), ST_IDLE);
    bus.nLOAD = 1'b1;
    tick();
    chk_out("E entry", 7, 1, 0);
    bus.nSTART  = 1'b1;
    bus.LOADVAL = 16'd9;
    bus.nLOAD   = 1'b0;
    tick();
    chk_out("E load in RUN k=1", 7, 1, 0);
    tick();
    chk_out("E load in RUN k=2", 7, 1, 0);
    bus.nLOAD = 1'b1;
    tick();
    chk_out("E k=3", 7, 1, 0);
    tick();
    chk_out("E k=4", 6, 1, 0);

    // Reset while PAUSED
    bus.nPAUSE = 1'b0;
    tick();
    chk("F paused state", 32'(dut.state_q), ST_PAUSED);
    nRESET = 1'b0;
    tick();
    chk_out("F reset", 0, 0, 0);
    chk("F reset state", 32'(dut.state_q), ST_IDLE);
    nRESET     = 1'b1;
    bus.nPAUSE = 1'b1;
`else
    // Auto-reload: LOADVAL=2 -> one-cycle EXPIRED pulse every 8 cycles
    bus.LOADVAL = 16'd2;
    bus.nLOAD   = 1'b0;
    tick();
    bus.nLOAD  = 1'b1;
    bus.nSTART = 1'b0;
    tick();
    chk_out("R entry", 2, 1, 0);
    bus.nSTART = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_out($sformatf("R k=%0d", k), ((k % 8) >= 4) ? 1 : 2, 1, ((k % 8) == 0) ? 1 : 0);
    end
    chk("R state", 32'(dut.state_q), ST_RUN);

    // Shadow 0 still gives DONE with a held EXPIRED
    nRESET = 1'b0;
    tick();
    chk_out("R reset", 0, 0, 0);
    nRESET      = 1'b1;
    bus.LOADVAL = 16'd0;
    bus.nLOAD   = 1'b0;
    tick();
    bus.nLOAD  = 1'b1;
    bus.nSTART = 1'b0;
    tick();
    chk_out("R start0", 0, 0, 1);
    bus.nSTART = 1'b1;
    tick();
    tick();
    chk_out("R hold", 0, 0, 1);
    chk("R done state", 32'(dut.state_q), ST_DONE);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 8192: MCLK cycles per one-second tick; legal range 2..2^24-1.
REQ-002 The block SHALL have port MCLK, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 The block SHALL have port nRESET, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port LOADVAL, input, 16 bits: countdown start value in seconds, unsigned.
REQ-005 The block SHALL have port nLOAD, input, 1 bit: active-low load strobe, sampled every edge.
REQ-006 The block SHALL have port nSTART, input, 1 bit: active-low start strobe.
REQ-007 The block SHALL have port nPAUSE, input, 1 bit: active-low level hold; low freezes counting.
REQ-008 The block SHALL have port TIMEREMAINING, output reg, 16 bits: seconds left.
REQ-009 The block SHALL have port BUSY, output reg, 1 bit: high in RUN or PAUSED.
REQ-010 The block SHALL have port EXPIRED, output reg, 1 bit: expiry indication (form per Configuration).

Function
REQ-011 The block SHALL implement states IDLE, RUN, PAUSED and DONE in a 2-bit state register.
REQ-012 In IDLE or DONE, nLOAD low SHALL load TIMEREMAINING<=LOADVAL and a shadow register<=LOADVAL, clear EXPIRED, and move to IDLE.
REQ-013 nLOAD SHALL be ignored in RUN and PAUSED.
REQ-014 In IDLE, nSTART low with nLOAD high SHALL clear the prescaler and move to RUN if TIMEREMAINING!=0, or to DONE with EXPIRED<=1 if TIMEREMAINING==0.
REQ-015 In IDLE, nLOAD and nSTART low on the same edge SHALL perform only the load; start requires a later edge.
REQ-016 nSTART SHALL be ignored outside IDLE.
REQ-017 In RUN, the prescaler SHALL increment by 1 per cycle from 0 up to PRESCALE-1.
REQ-018 In RUN, when the prescaler equals PRESCALE-1, the block SHALL, on that edge, reset the prescaler to 0 and decrement TIMEREMAINING by 1 (16-bit, never below 0).
REQ-019 In RUN, the decrement from 1 to 0 SHALL assert EXPIRED on the same edge, with no extra latency.
REQ-020 The first tick after start SHALL occur exactly PRESCALE cycles after the RUN-entry edge.
REQ-021 In RUN, nPAUSE low SHALL move to PAUSED; the prescaler and TIMEREMAINING hold for that edge and all following edges while in PAUSED.
REQ-022 In PAUSED, nPAUSE high SHALL return to RUN; counting resumes from the held prescaler value with no tick lost or duplicated.
REQ-023 In RUN, nPAUSE low on the terminal-tick edge SHALL take priority: no decrement and no expiry on that edge.
REQ-024 BUSY SHALL be registered and equal to (next state is RUN or PAUSED).

Reset
REQ-025 nRESET low on any edge SHALL force IDLE, prescaler 0, shadow 0, TIMEREMAINING 16'd0, BUSY 0 and EXPIRED 0, overriding all other inputs, including mid-RUN and mid-PAUSED.
REQ-026 All registers SHALL also carry matching power-up initial values.

Configuration
REQ-027 With macro COUNTDOWN_AUTORELOAD_EN undefined, expiry SHALL move RUN to DONE and hold EXPIRED high (a level) until nLOAD or nRESET.
REQ-028 With COUNTDOWN_AUTORELOAD_EN defined, expiry SHALL keep the block in RUN, reload TIMEREMAINING from the shadow on the same edge, and pulse EXPIRED high for exactly one cycle per expiry.
REQ-029 With COUNTDOWN_AUTORELOAD_EN defined and a shadow value of 0, REQ-014 SHALL still apply: enter DONE with EXPIRED held high.
REQ-030 The macro SHALL not change the port list.

Verification (PRESCALE=4)
REQ-031 The bench SHALL cover: LOADVAL=3 load, then nSTART -> TIMEREMAINING 3,2,1,0 at 4, 8 and 12 cycles after RUN entry; EXPIRED high with the 0 value; BUSY low from that edge.
REQ-032 The bench SHALL cover: LOADVAL=0 load, then nSTART -> DONE and EXPIRED=1 one edge later; BUSY never high.
REQ-033 The bench SHALL cover: nPAUSE low for 10 cycles mid-count with LOADVAL=2 -> expiry delayed by exactly 10 cycles versus the unpaused run.
REQ-034 The bench SHALL cover: nRESET low during RUN with TIMEREMAINING=5 -> next edge all outputs 0, state IDLE; a following nSTART gives immediate DONE.
REQ-035 The bench SHALL cover: nLOAD with nSTART on the same edge in IDLE (LOADVAL=7) -> TIMEREMAINING=7, BUSY=0; nLOAD during RUN -> ignored.
REQ-036 The bench SHALL cover, with COUNTDOWN_AUTORELOAD_EN defined: LOADVAL=2 -> EXPIRED one-cycle pulses every 8 cycles, TIMEREMAINING 2,1,2,1..., BUSY stays 1.
